// File: rtl/t_small_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : t_small_pkg
//  Brief    : Shared types and constants for the t-small polynomial decoder
//             (coefficient encodings, code field width, FSM state type).
//  Revision : 1.0 - initial release
// ============================================================================
package t_small_pkg;

    // Two's-complement ternary coefficient encodings
    localparam logic [1:0] COEF_NEG  = 2'b11;
    localparam logic [1:0] COEF_ZERO = 2'b00;
    localparam logic [1:0] COEF_POS  = 2'b01;

    // Low code field of each sorted word; value 3 has no meaning
    localparam int         LOW_BITS_W   = 2;
    localparam logic [1:0] CODE_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // coef = code - 1; the illegal code collapses to zero
    function automatic logic [1:0] decode_coef(input logic [LOW_BITS_W-1:0] code);
        logic [1:0] res;
        case (code)
            2'd0:    res = COEF_NEG;
            2'd1:    res = COEF_ZERO;
            2'd2:    res = COEF_POS;
            default: res = COEF_ZERO;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/t_small_decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : t_small_decode_if
//  Brief    : Control, RAM read port and coefficient stream of the decoder.
//             slave = decoder side, master = controller/RAM/sink side.
//  Revision : 1.0 - initial release
// ============================================================================
interface t_small_decode_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              coef_valid;
    logic              coef_ready;
    logic [1:0]        coef_out;
    logic [ADDR_W-1:0] coef_index;
    logic              code_err;
    logic              order_err;

    modport slave (
        input  start, rd_data, coef_ready,
        output busy, done, rd_en, rd_addr, coef_valid, coef_out, coef_index,
               code_err, order_err
    );

    modport master (
        output start, rd_data, coef_ready,
        input  busy, done, rd_en, rd_addr, coef_valid, coef_out, coef_index,
               code_err, order_err
    );
endinterface
`default_nettype wire

// File: rtl/t_small_decode_compare.sv
`default_nettype none
// ============================================================================
//  Module   : compare
//  Brief    : Unsigned magnitude comparator, L_smaller = (dinL < dinR).
//             Only present when T_SMALL_DECODE_ORDER_CHECK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`ifdef T_SMALL_DECODE_ORDER_CHECK_EN
module compare #(
    parameter int WIDTH = 32
) (
    input  wire logic [WIDTH-1:0] dinL,
    input  wire logic [WIDTH-1:0] dinR,
    output logic                  L_smaller
);
    assign L_smaller = (dinL < dinR);
endmodule
`endif
`default_nettype wire

// File: rtl/t_small_decode.sv
`default_nettype none
// ============================================================================
//  Module   : t_small_decode
//  Brief    : Reads N sorted words back from RAM, strips the random key and
//             streams the ternary coefficients over valid/ready. Flags
//             illegal codes; with T_SMALL_DECODE_ORDER_CHECK_EN defined it
//             also flags any descending pair of words (order_err).
//  Revision : 1.0 - initial release
// ============================================================================
module t_small_decode
    import t_small_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N      = 761,
    parameter int ADDR_W = 10
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    t_small_decode_if.slave  bus
);

    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(N - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_coef;
    logic              r_code_err;
    logic              w_busy;
    logic              w_done;
    logic              w_rd_en;
    logic              w_valid;
    logic              w_last;
    logic              w_unused_key;

    assign w_last       = (r_idx == C_LAST_IDX);
    assign w_unused_key = ^bus.rd_data[WIDTH-1:LOW_BITS_W];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and Moore outputs
    always_comb begin
        w_next  = r_state;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_rd_en = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_FETCH;
            ST_FETCH: begin
                w_busy  = 1'b1;
                w_rd_en = 1'b1;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                w_busy = 1'b1;
                w_next = ST_EMIT;
            end
            ST_EMIT: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                if (bus.coef_ready) w_next = w_last ? ST_FIN : ST_FETCH;
            end
            ST_FIN: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Index counter, decoded coefficient and sticky code error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_coef     <= 2'b00;
            r_code_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) begin
                    r_idx      <= '0;
                    r_code_err <= 1'b0;
                end
                ST_WAIT: begin
                    r_coef <= decode_coef(bus.rd_data[LOW_BITS_W-1:0]);
                    if (bus.rd_data[LOW_BITS_W-1:0] == CODE_ILLEGAL) r_code_err <= 1'b1;
                end
                ST_EMIT: if (bus.coef_ready && !w_last) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef T_SMALL_DECODE_ORDER_CHECK_EN
    logic [WIDTH-1:0] r_prev;
    logic             r_order_err;
    logic             w_l_smaller;

    compare #(.WIDTH(WIDTH)) u_compare (
        .dinL      (bus.rd_data),
        .dinR      (r_prev),
        .L_smaller (w_l_smaller)
    );

    // Previous-word tracking; the first word of a polynomial is never compared
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev      <= '0;
            r_order_err <= 1'b0;
        end else if (r_state == ST_IDLE && bus.start) begin
            r_order_err <= 1'b0;
        end else if (r_state == ST_WAIT) begin
            r_prev <= bus.rd_data;
            if (r_idx != '0 && w_l_smaller) r_order_err <= 1'b1;
        end
    end

    assign bus.order_err = r_order_err;
`else
    assign bus.order_err = 1'b0;
`endif

    // rd_addr follows idx, which only moves on the way into FETCH
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.rd_en      = w_rd_en;
    assign bus.rd_addr    = r_idx;
    assign bus.coef_valid = w_valid;
    assign bus.coef_out   = r_coef;
    assign bus.coef_index = r_idx;
    assign bus.code_err   = r_code_err;

endmodule
`default_nettype wire

// File: tb/tb_t_small_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_t_small_decode
//  Brief    : Self-checking bench for t_small_decode with N=4 and a 1-cycle
//             RAM model; expected coefficients come from a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_t_small_decode;

    localparam int WIDTH  = 32;
    localparam int N      = 4;
    localparam int ADDR_W = 10;

    typedef struct {
        int         idx;
        logic [1:0] coef;
        logic       ce;
        logic       oe;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [WIDTH-1:0] mem [N];
    exp_t sb [$];
    int n_asserts = 0;
    int n_fail    = 0;

    t_small_decode_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    t_small_decode #(.WIDTH(WIDTH), .N(N), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data valid one cycle after rd_en
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[1:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_coef(input logic [1:0] code);
        case (code)
            2'd0:    return 2'b11;
            2'd1:    return 2'b00;
            2'd2:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check(tag, {bus.busy, bus.done, bus.rd_en, bus.coef_valid, bus.code_err,
                    bus.order_err, bus.coef_out, bus.coef_index, bus.rd_addr}, 32'd0);
    endtask

    task automatic load(input logic [31:0] w0, w1, w2, w3);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    // One polynomial. mode 0: ready held 1; mode 1: ready toggles.
    task automatic run_poly(input int mode, input int abort_idx,
                            input bit start_busy, input bit start_fin);
        int cyc, hs, dn, rds, first_valid;
        bit fin_seen, prev_stall;
        logic [1:0] prev_coef;
        logic [ADDR_W-1:0] prev_idx;
        logic ce, oe;
        exp_t e;
        ce = 1'b0; oe = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (mem[i][1:0] == 2'b11) ce = 1'b1;
`ifdef T_SMALL_DECODE_ORDER_CHECK_EN
            if (i > 0 && mem[i] < mem[i-1]) oe = 1'b1;
`endif
            e.idx = i; e.coef = exp_coef(mem[i][1:0]); e.ce = ce; e.oe = oe;
            sb.push_back(e);
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("errs_cleared_on_start", {bus.code_err, bus.order_err}, 0);
        cyc = 1; hs = 0; dn = 0; rds = 0; first_valid = -1;
        fin_seen = 0; prev_stall = 0; prev_coef = 0; prev_idx = 0;
        while (!fin_seen && cyc < 200) begin
            bus.coef_ready = (mode == 0) ? 1'b1 : cyc[0];
            bus.start = (start_busy && cyc == 5);
            if (bus.rd_en) rds++;
            if (prev_stall)
                check("hold_while_stalled", {bus.coef_valid, bus.coef_out, bus.coef_index},
                      {1'b1, prev_coef, prev_idx});
            if (bus.coef_valid && first_valid < 0) begin
                first_valid = cyc;
                check("first_valid_latency", cyc, 3);
            end
            if (abort_idx >= 0 && bus.coef_valid && int'(bus.coef_index) == abort_idx) begin
                rst_n = 1'b0; bus.coef_ready = 1'b0; bus.start = 1'b0;
                @(posedge clk); #1;
                check_all_zero("outputs_after_mid_reset");
                rst_n = 1'b1;
                sb.delete();
                repeat (4) begin
                    @(posedge clk); #1;
                    check("idle_no_done_after_reset", {bus.done, bus.busy, bus.rd_en}, 0);
                end
                return;
            end
            if (bus.coef_valid && bus.coef_ready) begin
                hs++;
                if (mode == 0) check("throughput_3cyc", cyc, 3 * hs);
                if (sb.size() == 0) begin
                    check("unexpected_handshake", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("coef_index", bus.coef_index, e.idx);
                    check("coef_out", bus.coef_out, e.coef);
                    check("code_err_running", bus.code_err, e.ce);
                    check("order_err_running", bus.order_err, e.oe);
                end
            end
            if (bus.done) begin
                dn++;
                fin_seen = 1;
                check("busy_low_with_done", bus.busy, 0);
                if (start_fin) bus.start = 1'b1;
            end
            prev_stall = bus.coef_valid && !bus.coef_ready;
            prev_coef  = bus.coef_out;
            prev_idx   = bus.coef_index;
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        check("done_within_budget", fin_seen, 1);
        check("handshake_count", hs, N);
        check("done_count", dn, 1);
        check("rd_en_count", rds, N);
        check("scoreboard_empty", sb.size(), 0);
        sb.delete();
        bus.coef_ready = 1'b0;
        repeat (6) begin
            check("idle_after_done_sticky",
                  {bus.rd_en, bus.done, bus.busy, bus.coef_valid, bus.code_err, bus.order_err},
                  {4'b0000, ce, oe});
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.coef_ready = 1'b0;
        bus.rd_data = '0;
        load(32'h100, 32'h201, 32'h302, 32'h401);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic stream, ready held high
        run_poly(0, -1, 0, 0);
        // Backpressure: ready toggling
        run_poly(1, -1, 0, 0);
        // Illegal code at idx 2; sticky after done, cleared by next start
        load(32'h100, 32'h201, 32'h303, 32'h401);
        run_poly(0, -1, 0, 0);
        load(32'h100, 32'h201, 32'h302, 32'h401);
        run_poly(1, -1, 0, 0);
        // Descending pair at idx 2
        load(32'h10, 32'h20, 32'h1C, 32'h30);
        run_poly(0, -1, 0, 0);
        // Equal neighbours are legal
        load(32'h10, 32'h20, 32'h20, 32'h30);
        run_poly(1, -1, 0, 0);
        // Reset in EMIT at idx 1, then a fresh decode
        load(32'h100, 32'h201, 32'h302, 32'h401);
        run_poly(0, 1, 0, 0);
        run_poly(0, -1, 0, 0);
        // start while busy and start in FIN are both ignored
        run_poly(0, -1, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
